// File: rtl/jugador_disparo_if.sv
`default_nettype none
// ============================================================================
// Module      : jugador_disparo_if
// Description : Board, shot-request and shot-result bundle between the game
//               FSM / display path and the player-shot resolver.
// Revision    : 1.0 - initial release
// ============================================================================
interface jugador_disparo_if #(
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int COORD_W = 3,
    parameter int CNT_W   = 5
);
    logic [ROWS-1:0][COLS-1:0][2:0] pc_board;
    logic [2:0]                     estado;
    logic                           turno;
    logic                           disparo;
    logic [COORD_W-1:0]             x;
    logic [COORD_W-1:0]             y;
    logic [ROWS-1:0][COLS-1:0][2:0] updated_pc_board;
    logic                           hecho;
    logic                           acierto;
    logic                           fallo;
    logic                           invalido;
    logic                           turno_fin;
    logic [CNT_W-1:0]               barcos_restantes;
    logic                           flota_hundida;

    modport master (
        output pc_board, estado, turno, disparo, x, y,
        input  updated_pc_board, hecho, acierto, fallo, invalido,
               turno_fin, barcos_restantes, flota_hundida
    );

    modport slave (
        input  pc_board, estado, turno, disparo, x, y,
        output updated_pc_board, hecho, acierto, fallo, invalido,
               turno_fin, barcos_restantes, flota_hundida
    );
endinterface
`default_nettype wire

// File: rtl/jugador_disparo.sv
`default_nettype none
// ============================================================================
// Module      : jugador_disparo
// Description : Player-shot resolver: loads the PC board, resolves one shot
//               per rising edge of disparo, marks hit/miss, counts ship cells.
//               Optional macro JUGADOR_RECHAZO_REPETIDO_EN rejects repeat shots.
// Revision    : 1.0 - initial release
// ============================================================================
module jugador_disparo #(
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int COORD_W = 3,
    parameter int CNT_W   = 5
) (
    input wire clk,
    input wire reset,
    jugador_disparo_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_APPLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] c_cell_water = 3'b001;
    localparam logic [2:0] c_cell_ship  = 3'b010;
    localparam logic [2:0] c_cell_hit   = 3'b011;
    localparam logic [2:0] c_cell_miss  = 3'b100;
    localparam logic [2:0] c_est_load   = 3'b000;
    localparam logic [2:0] c_est_shoot  = 3'b010;
    localparam logic [1:0] c_res_hit    = 2'd0;
    localparam logic [1:0] c_res_miss   = 2'd1;
    localparam logic [1:0] c_res_inval  = 2'd2;

    state_t                         r_state;
    state_t                         w_next_state;
    logic [ROWS-1:0][COLS-1:0][2:0] r_board;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_cargado;
    logic                           r_disparo_q;
    logic [COORD_W-1:0]             r_x;
    logic [COORD_W-1:0]             r_y;
    logic [1:0]                     r_res;
    logic                           r_wr;

    logic                           w_load;
    logic                           w_accept;
    logic                           w_in_range;
    logic [2:0]                     w_target;
    logic [CNT_W-1:0]               w_ships;
    logic [1:0]                     w_res;
    logic                           w_wr;
    logic                           w_hecho;
    logic                           w_acierto;
    logic                           w_fallo;
    logic                           w_invalido;
    logic                           w_turno_fin;

    assign w_load   = (r_state == S_IDLE) && (bus.estado == c_est_load);
    assign w_accept = (r_state == S_IDLE) && (bus.estado == c_est_shoot) &&
                      bus.turno && bus.disparo && !r_disparo_q;
    assign w_in_range = (32'(r_x) < ROWS) && (32'(r_y) < COLS);

    // Cell lookup by comparison so out-of-range coordinates never index the array
    always_comb begin
        w_target = '0;
        w_ships  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_x == COORD_W'(r) && r_y == COORD_W'(c))
                    w_target = r_board[r][c];
                if (bus.pc_board[r][c] == c_cell_ship)
                    w_ships = w_ships + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_res = c_res_inval;
        w_wr  = 1'b0;
        if (w_in_range) begin
            case (w_target)
                c_cell_ship: begin
                    w_res = c_res_hit;
                    w_wr  = 1'b1;
                end
                c_cell_hit, c_cell_miss: begin
`ifdef JUGADOR_RECHAZO_REPETIDO_EN
                    w_res = c_res_inval;
`else
                    w_res = c_res_miss;
`endif
                    w_wr  = 1'b0;
                end
                default: begin
                    w_res = c_res_miss;
                    w_wr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_hecho      = 1'b0;
        w_acierto    = 1'b0;
        w_fallo      = 1'b0;
        w_invalido   = 1'b0;
        w_turno_fin  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_CHECK;
            S_CHECK: w_next_state = S_APPLY;
            S_APPLY: w_next_state = S_DONE;
            S_DONE: begin
                w_next_state = S_IDLE;
                w_hecho      = 1'b1;
                w_acierto    = (r_res == c_res_hit);
                w_fallo      = (r_res == c_res_miss);
                w_invalido   = (r_res == c_res_inval);
                w_turno_fin  = (r_res != c_res_inval);
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_board     <= '0;
            r_cnt       <= '0;
            r_cargado   <= 1'b0;
            r_disparo_q <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_res       <= c_res_inval;
            r_wr        <= 1'b0;
        end else begin
            r_disparo_q <= bus.disparo;
            if (w_accept) begin
                r_x <= bus.x;
                r_y <= bus.y;
            end
            if (w_load) begin
                r_board   <= bus.pc_board;
                r_cnt     <= w_ships;
                r_cargado <= 1'b1;
            end
            if (r_state == S_CHECK) begin
                r_res <= w_res;
                r_wr  <= w_wr;
            end
            if (r_state == S_APPLY && r_wr) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (r_x == COORD_W'(r) && r_y == COORD_W'(c))
                            r_board[r][c] <= (r_res == c_res_hit) ? c_cell_hit : c_cell_miss;
                    end
                end
                if (r_res == c_res_hit && r_cnt != '0)
                    r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.updated_pc_board = r_board;
    assign bus.barcos_restantes = r_cnt;
    assign bus.flota_hundida    = r_cargado && (r_cnt == '0);
    assign bus.hecho            = w_hecho;
    assign bus.acierto          = w_acierto;
    assign bus.fallo            = w_fallo;
    assign bus.invalido         = w_invalido;
    assign bus.turno_fin        = w_turno_fin;

    // Water code is referenced only for documentation of the cell alphabet
    logic w_unused;
    assign w_unused = ^c_cell_water;
endmodule
`default_nettype wire
